// File: rtl/btn_conditioner.sv
// Button conditioner: per-channel 2-flop synchronizer, debounce FSM, press/release pulses.
// Define BTN_COND_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_conditioner #(
    parameter int N_CH         = 4,
    parameter int STABLE_CNT   = 4,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_CH-1:0] noisy_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            any_pressed
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CNT);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } state_t;

    if (N_CH < 1 || N_CH > 16 || STABLE_CNT < 2 || STABLE_CNT > 255 ||
        HOLD_TICKS < 1 || HOLD_TICKS > 1023 ||
        REPEAT_TICKS < 1 || REPEAT_TICKS > 1023) begin : g_param_check
        $error("btn_conditioner: parameter out of range");
    end

    logic [N_CH-1:0] sync_meta;
    logic [N_CH-1:0] sync_q;
    logic [N_CH-1:0] level_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= noisy_in;
            sync_q    <= sync_meta;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             accept_rise;
        logic             accept_fall;
        logic             rpt_fire;

        // The tick that would bring the counter up to STABLE_CNT is the accepting tick.
        assign accept_rise = tick && (state == CHK_HIGH) &&  sync_q[ch] && (cnt >= CNT_LAST);
        assign accept_fall = tick && (state == CHK_LOW)  && !sync_q[ch] && (cnt >= CNT_LAST);
        assign level_nxt[ch] = accept_rise | (level_q & ~accept_fall);

        assign level_out[ch]     = level_q;
        assign press_pulse[ch]   = press_q;
        assign release_pulse[ch] = release_q;

`ifdef BTN_COND_AUTOREPEAT_EN
        logic [9:0] rpt_cnt;
        logic       rpt_phase;
        logic [9:0] rpt_target;

        assign rpt_target = rpt_phase ? 10'(REPEAT_TICKS) : 10'(HOLD_TICKS);
        assign rpt_fire   = tick && (state == HIGH) && sync_q[ch] &&
                            ((rpt_cnt + 10'd1) == rpt_target);

        // Counts held ticks; first period is HOLD_TICKS, later ones REPEAT_TICKS.
        always_ff @(posedge clk) begin
            if (rst || (state != HIGH)) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b0;
            end else if (tick) begin
                if (!sync_q[ch]) begin
                    rpt_cnt   <= '0;
                    rpt_phase <= 1'b0;
                end else if (rpt_fire) begin
                    rpt_cnt   <= '0;
                    rpt_phase <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_cnt + 10'd1;
                end
            end
        end
`else
        assign rpt_fire = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= LOW;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                level_q   <= level_nxt[ch];
                press_q   <= accept_rise | rpt_fire;
                release_q <= accept_fall;
                if (tick) begin
                    case (state)
                        LOW: begin
                            if (sync_q[ch]) begin
                                state <= CHK_HIGH;
                                cnt   <= CNT_W'(1);
                            end
                        end
                        CHK_HIGH: begin
                            if (!sync_q[ch]) begin
                                state <= LOW;
                                cnt   <= '0;
                            end else if (accept_rise) begin
                                state <= HIGH;
                                cnt   <= '0;
                            end else if (cnt != CNT_MAX) begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        HIGH: begin
                            if (!sync_q[ch]) begin
                                state <= CHK_LOW;
                                cnt   <= CNT_W'(1);
                            end
                        end
                        CHK_LOW: begin
                            if (sync_q[ch]) begin
                                state <= HIGH;
                                cnt   <= '0;
                            end else if (accept_fall) begin
                                state <= LOW;
                                cnt   <= '0;
                            end else if (cnt != CNT_MAX) begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= LOW;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |level_nxt;
        end
    end

endmodule
